// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter: round-robin arbiter with a bounded burst lock for the register file write port
//   clk          rising-edge clock
//   reset        asynchronous active-low reset
//   stall        1 = accept nothing this cycle
//   req_valid    per-requester write request
//   req_addr     destination register, 2 bits per requester
//   req_data     write data, 8 bits per requester
//   req_lock     1 = keep the grant for the next beat
//   req_ready    one-hot (or zero) accept strobe, combinational
//   sigRegWrite  registered register file write enable
//   writeReg     registered register file write address
//   writeData    registered register file write data
//   grant_id     requester that owns the current write
//   locked       a lock is in force
module regfile_write_arbiter #(
    parameter int NREQ     = 3,
    parameter int LOCK_MAX = 4,
    parameter int IDW      = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [2*NREQ-1:0] req_addr,
    input  logic [8*NREQ-1:0] req_data,
    input  logic [NREQ-1:0]   req_lock,
    output logic [NREQ-1:0]   req_ready,
    output logic              sigRegWrite,
    output logic [1:0]        writeReg,
    output logic [7:0]        writeData,
    output logic [IDW-1:0]    grant_id,
    output logic              locked
);
    typedef enum logic {UNLOCKED, LOCKED} lockState_t;
    lockState_t state, stateNext;
    logic [IDW-1:0] owner, ownerNext, ptr, ptrNext;
    logic [IDW-1:0] lowAll, lowUp, rrWinner, winner;
    logic [3:0] count, countNext;
    logic foundUp, ownerWins, grantOn, ownerAccept, freshAccept, lockIt;
    function automatic logic [IDW-1:0] ptrInc(input logic [IDW-1:0] x);
        return (x == IDW'(NREQ-1)) ? '0 : x + 1'b1;
    endfunction
    // Round robin: lowest valid index at or above ptr, else lowest valid overall.
    always_comb begin
        lowAll = '0;
        lowUp = '0;
        foundUp = 1'b0;
        for (int i = NREQ-1; i >= 0; i--) begin
            if (req_valid[i]) lowAll = IDW'(i);
            if (req_valid[i] && IDW'(i) >= ptr) begin
                lowUp = IDW'(i);
                foundUp = 1'b1;
            end
        end
        rrWinner = foundUp ? lowUp : lowAll;
    end
    assign ownerWins   = (state == LOCKED) && req_valid[owner];
    assign grantOn     = !stall && |req_valid;
    assign winner      = ownerWins ? owner : rrWinner;
    assign req_ready   = grantOn ? NREQ'(1) << winner : '0;
    assign ownerAccept = grantOn && ownerWins;
    assign freshAccept = grantOn && !ownerWins;
    assign lockIt      = req_lock[winner] && (LOCK_MAX > 1);
    assign locked      = (state == LOCKED);
    // count holds the beats already granted in this burst; the beat that
    // brings it to LOCK_MAX is written and then the lock is forcibly dropped.
    always_comb begin
        stateNext = state;
        ownerNext = owner;
        countNext = count;
        ptrNext = ptr;
        if (freshAccept) begin
            stateNext = lockIt ? LOCKED : UNLOCKED;
            ownerNext = winner;
            countNext = lockIt ? 4'd1 : 4'd0;
            ptrNext = ptrInc(winner);
        end else if (ownerAccept) begin
            if (req_lock[owner] && (int'(count) + 1 < LOCK_MAX)) begin
                countNext = count + 4'd1;
            end else begin
                stateNext = UNLOCKED;
                countNext = 4'd0;
                ptrNext = ptrInc(owner);
            end
        end else if (state == LOCKED && !stall) begin
            stateNext = UNLOCKED;
            countNext = 4'd0;
        end
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= UNLOCKED;
            owner <= '0;
            count <= '0;
            ptr <= '0;
            sigRegWrite <= 1'b0;
            writeReg <= '0;
            writeData <= '0;
            grant_id <= '0;
        end else begin
            state <= stateNext;
            owner <= ownerNext;
            count <= countNext;
            ptr <= ptrNext;
            sigRegWrite <= grantOn;
            if (grantOn) begin
                writeReg <= req_addr[{winner, 1'b0} +: 2];
                writeData <= req_data[{winner, 3'b000} +: 8];
                grant_id <= winner;
            end
        end
    end
endmodule
